// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller command path:
// one-hot state codes, the NOP command and a constant-safe clog2.
package sdram_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'b0001;
    localparam state_t ST_ARBIT = 4'b0010;
    localparam state_t ST_AREF  = 4'b0100;
    localparam state_t ST_GRANT = 4'b1000;

    // {cs_n,ras_n,cas_n,we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) res = 32'(i + 1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req searching
// upward (with wrap) from last+1.
module rr_pick
    import sdram_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] index
);

    int unsigned   pos;
    logic [IW-1:0] cand;

    // Walk candidates farthest-first so the nearest requester overwrites.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            pos  = (32'(last) + k) % N;
            cand = IW'(pos);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// SDRAM command-bus arbiter: init pass-through, refresh at top priority,
// round-robin client grants, pin muxing and a per-grant watchdog.
module sdram_arbiter_rr
    import sdram_pkg::*;
#(
    parameter int unsigned NUM_CLI = 4,
    parameter int unsigned AW      = 13,
    parameter int unsigned BW      = 2,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       sclk,
    input  logic                       reset,
    input  logic                       init_done,
    input  logic [3:0]                 init_cmd,
    input  logic [AW-1:0]              init_addr,
    input  logic                       ref_req,
    output logic                       ref_en,
    input  logic                       ref_end,
    input  logic [3:0]                 ref_cmd,
    input  logic [AW-1:0]              ref_addr,
    input  logic [NUM_CLI-1:0]         cli_req,
    output logic [NUM_CLI-1:0]         cli_en,
    input  logic [NUM_CLI-1:0]         cli_end,
    input  logic [4*NUM_CLI-1:0]       cli_cmd,
    input  logic [AW*NUM_CLI-1:0]      cli_addr,
    input  logic [BW*NUM_CLI-1:0]      cli_bank,
    input  logic [NUM_CLI-1:0]         cli_wr,
    input  logic [DW*NUM_CLI-1:0]      cli_wdata,
    output logic [3:0]                 sdram_cmd,
    output logic [AW-1:0]              sdram_addr,
    output logic [BW-1:0]              sdram_bank,
    output logic                       dq_oe,
    output logic [DW-1:0]              dq_out,
    output logic [clog2(NUM_CLI)-1:0]  grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IW = clog2(NUM_CLI);
    localparam int unsigned WW = clog2(TIMEOUT);

    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [WW-1:0]      wd, wd_nxt;
    logic               ref_en_nxt, to_nxt;
    logic [NUM_CLI-1:0] cli_en_nxt;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    int unsigned        gi;

    rr_pick #(.N(NUM_CLI), .IW(IW)) u_pick (
        .req   (cli_req),
        .last  (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // State register and registered outputs.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ref_en      <= 1'b0;
            cli_en      <= '0;
            timeout_err <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= IW'(NUM_CLI - 1);
            wd          <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ref_en      <= ref_en_nxt;
            cli_en      <= cli_en_nxt;
            timeout_err <= to_nxt;
            grant_id    <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            wd          <= wd_nxt;
            busy        <= (state_nxt == ST_AREF) || (state_nxt == ST_GRANT);
        end
    end

    // Next-state, grant selection and watchdog.
    always_comb begin
        state_nxt  = state;
        ref_en_nxt = 1'b0;
        cli_en_nxt = '0;
        to_nxt     = 1'b0;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        wd_nxt     = wd;
        case (state)
            ST_IDLE: begin
                if (init_done) state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    state_nxt  = ST_AREF;
                    ref_en_nxt = 1'b1;
                    wd_nxt     = '0;
                end else if (pick_valid) begin
                    state_nxt  = ST_GRANT;
                    cli_en_nxt = NUM_CLI'(1) << pick_idx;
                    grant_nxt  = pick_idx;
                    rr_ptr_nxt = pick_idx;
                    wd_nxt     = '0;
                end
            end
            ST_AREF, ST_GRANT: begin
                wd_nxt = wd + WW'(1);
                // An end pulse in the last watchdog cycle still counts as a clean end.
                if ((state == ST_AREF) ? ref_end : cli_end[grant_id]) begin
                    state_nxt = ST_ARBIT;
                end else if (wd == WW'(TIMEOUT - 1)) begin
                    state_nxt = ST_ARBIT;
                    to_nxt    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pin mux from the registered state and grant.
    always_comb begin
        gi         = 32'(grant_id);
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = '0;
        dq_oe      = 1'b0;
        dq_out     = '0;
        case (state)
            ST_ARBIT: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_GRANT: begin
                sdram_cmd  = cli_cmd[4*gi +: 4];
                sdram_addr = cli_addr[AW*gi +: AW];
                sdram_bank = cli_bank[BW*gi +: BW];
                dq_oe      = cli_wr[grant_id];
                dq_out     = cli_wdata[DW*gi +: DW];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sdram_arbiter_rr.md
Name: sdram_arbiter_rr

Overview:
- Parametrised command arbiter for the SDRAM controller.
- Sequences the init phase, then grants the SDRAM command bus to auto-refresh (fixed top priority) or to one of NUM_CLI read/write clients, chosen round-robin.
- Muxes the granted requester's cmd/addr/bank/write-data onto the SDRAM pins.
- Adds a per-grant watchdog that reclaims the bus from a client that never signals end.

Parameters:
NUM_CLI, 4, number of read/write clients (2..8)
AW, 13, SDRAM address width
BW, 2, bank address width
DW, 16, data width
TIMEOUT, 1024, max cycles a grant (refresh or client) may last before forced release (power of 2, >=16)

Ports:
sclk  in  1  system clock
reset  in  1  asynchronous reset, active-high
init_done  in  1  init sequencer finished (level)
init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer
init_addr  in  AW  address from init sequencer
ref_req  in  1  refresh request
ref_en  out  1  one-cycle refresh grant pulse
ref_end  in  1  refresh sequence complete pulse
ref_cmd  in  4  refresh command
ref_addr  in  AW  refresh address
cli_req  in  NUM_CLI  per-client request (level, held until granted)
cli_en  out  NUM_CLI  one-hot one-cycle grant pulse
cli_end  in  NUM_CLI  per-client burst-complete pulse
cli_cmd  in  4*NUM_CLI  packed client commands, client i at [4i+3:4i]
cli_addr  in  AW*NUM_CLI  packed client addresses
cli_bank  in  BW*NUM_CLI  packed client banks
cli_wr  in  NUM_CLI  client i is driving write data this cycle
cli_wdata  in  DW*NUM_CLI  packed client write data
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
sdram_addr  out  AW  address to pins
sdram_bank  out  BW  bank to pins
dq_oe  out  1  DQ tristate enable
dq_out  out  DW  DQ output data
grant_id  out  clog2(NUM_CLI)  index of current or last client grant
busy  out  1  state is AREF or GRANT
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset values: state IDLE; ref_en=0; cli_en=0; timeout_err=0; grant_id=0; rr pointer=NUM_CLI-1 (client 0 wins first); watchdog=0.
- States: IDLE, ARBIT, AREF, GRANT.
- IDLE: outputs follow init_cmd/init_addr; bank=0; dq_oe=0. On init_done=1, next state is ARBIT. A later drop of init_done is ignored.
- ARBIT decision, evaluated each cycle:
  - ref_req=1 -> next state AREF; ref_en=1 for exactly the next cycle.
  - Else if any cli_req -> select the first requester searching upward (with wrap) from rr pointer+1. Next state GRANT. cli_en[sel]=1 for exactly the next cycle. grant_id<=sel. rr pointer<=sel.
  - Else stay in ARBIT.
  - ARBIT outputs: NOP 4'b0111, addr 0, bank 0, dq_oe 0.
- Latency: ARBIT decision, state change and the enable pulse all register on the same edge. From a request seen in ARBIT to the grant pulse is 1 cycle.
- AREF: outputs ref_cmd/ref_addr, bank 0. Returns to ARBIT on the cycle after ref_end=1.
- GRANT: outputs cli_cmd/addr/bank of grant_id. dq_oe=cli_wr[grant_id]; dq_out=cli_wdata[grant_id]. Returns to ARBIT on the cycle after cli_end[grant_id]=1. cli_end from non-granted clients is ignored.
- No preemption: ref_req arriving during GRANT waits for ARBIT. At the next ARBIT, refresh beats all clients.
- Watchdog:
  - Cleared on entry to AREF/GRANT; increments each cycle in those states.
  - When it equals TIMEOUT-1 with no end pulse: next state ARBIT, timeout_err pulses 1 cycle.
  - End pulse and timeout in the same cycle: end wins, no timeout_err.
- Output muxing (cmd/addr/bank/dq) is combinational from the registered state and grant_id. ref_en, cli_en and timeout_err are registered.
- dq_oe is 0 in every state except GRANT.
- Reset asserted mid-burst: immediate return to reset values, IDLE; bus shows init_cmd.

Decomposition:
- Package sdram_pkg holds:
  - state encoding localparams (one-hot, 4 bits)
  - CMD_NOP=4'b0111
  - a clog2 function
- Sub-module rr_pick: combinational round-robin selector with inputs (req vector, last pointer) and outputs (valid, index). It is reused by later multi-port front ends.

Test Plan:
1. Reset, init_done rises at cycle 10 -> state ARBIT at cycle 11; sdram_cmd=4'b0111 and dq_oe=0 while idle.
2. cli_req=4'b1111 held, each client pulses cli_end 5 cycles after its cli_en -> grant order 0,1,2,3,0; exactly one cli_en bit per grant.
3. ref_req and cli_req[2] both high in ARBIT -> ref_en pulses, sdram_cmd=ref_cmd; after ref_end, client 2 is granted on the next ARBIT.
4. Client 1 granted with cli_wr=1, cli_wdata[1]=16'hA5A5 -> dq_oe=1, dq_out=16'hA5A5, sdram_bank=cli_bank[1]; dq_oe=0 once back in ARBIT.
5. Client 3 granted and never ends, TIMEOUT=16 -> timeout_err pulses 16 cycles after entry; state ARBIT; next grant goes to client 0.
6. reset asserted during GRANT -> next edge: cli_en=0, busy=0, sdram_cmd=init_cmd; after release, client 0 has first priority.
